// File: rtl/cache_arbiter_if.sv
// Bus bundle between the two L1 caches, the cache arbiter and the cacheline adaptor.
// The slave modport is the arbiter's view; master is the caches and adaptor around it.
interface cache_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  logic              icache_read;
  logic [ADDR_W-1:0] icache_address;
  logic [LINE_W-1:0] icache_rdata;
  logic              icache_resp;

  logic              dcache_read;
  logic              dcache_write;
  logic [ADDR_W-1:0] dcache_address;
  logic [LINE_W-1:0] dcache_wdata;
  logic [LINE_W-1:0] dcache_rdata;
  logic              dcache_resp;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;

  modport slave (
    input  icache_read, icache_address,
    output icache_rdata, icache_resp,
    input  dcache_read, dcache_write, dcache_address, dcache_wdata,
    output dcache_rdata, dcache_resp,
    output mem_read, mem_write, mem_address, mem_wdata,
    input  mem_rdata, mem_resp
  );

  modport master (
    output icache_read, icache_address,
    input  icache_rdata, icache_resp,
    output dcache_read, dcache_write, dcache_address, dcache_wdata,
    input  dcache_rdata, dcache_resp,
    input  mem_read, mem_write, mem_address, mem_wdata,
    output mem_rdata, mem_resp
  );
endinterface

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one line-sized memory port between the L1 I-cache and D-cache.
// One transaction in flight; commands are registered, completion is routed to the granted cache.
module cache_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  cache_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e            state_q;
  logic              last_grant_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic [ADDR_W-1:0] mem_address_q;
  logic [LINE_W-1:0] mem_wdata_q;

  logic              i_req_s;
  logic              d_req_s;
  logic              pick_i_d;
  logic              pick_d_d;

  assign i_req_s = bus.icache_read;
  assign d_req_s = bus.dcache_read | bus.dcache_write;

  // Grant decision in IDLE; on a tie the side that was not served last wins.
  always_comb begin
    pick_i_d = 1'b0;
    pick_d_d = 1'b0;
    if (state_q == IDLE) begin
      if (i_req_s && d_req_s) begin
        if (last_grant_q) begin
          pick_i_d = 1'b1;
        end else begin
          pick_d_d = 1'b1;
        end
      end else if (i_req_s) begin
        pick_i_d = 1'b1;
      end else if (d_req_s) begin
        pick_d_d = 1'b1;
      end else begin
        pick_i_d = 1'b0;
        pick_d_d = 1'b0;
      end
    end else begin
      pick_i_d = 1'b0;
      pick_d_d = 1'b0;
    end
  end

  // Transaction FSM with registered memory command, address and write data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= {ADDR_W{1'b0}};
      mem_wdata_q   <= {LINE_W{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_i_d) begin
            state_q       <= I_BUSY;
            mem_read_q    <= 1'b1;
            mem_write_q   <= 1'b0;
            mem_address_q <= bus.icache_address;
            last_grant_q  <= 1'b0;
          end else if (pick_d_d) begin
            // A simultaneous read+write from the D-cache is treated as a write.
            state_q       <= D_BUSY;
            mem_read_q    <= ~bus.dcache_write;
            mem_write_q   <= bus.dcache_write;
            mem_address_q <= bus.dcache_address;
            mem_wdata_q   <= bus.dcache_wdata;
            last_grant_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        I_BUSY, D_BUSY: begin
          if (bus.mem_resp) begin
            state_q     <= DONE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
          end else begin
            state_q <= state_q;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q     <= IDLE;
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_read     = mem_read_q;
  assign bus.mem_write    = mem_write_q;
  assign bus.mem_address  = mem_address_q;
  assign bus.mem_wdata    = mem_wdata_q;

  // Line data goes to both caches; only the completion pulse is steered by the grant.
  assign bus.icache_rdata = bus.mem_rdata;
  assign bus.dcache_rdata = bus.mem_rdata;
  assign bus.icache_resp  = (state_q == I_BUSY) & bus.mem_resp;
  assign bus.dcache_resp  = (state_q == D_BUSY) & bus.mem_resp;

endmodule
